id_ex_skid: RTL
===============

ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand width (reg1/reg2).
REQ-002 SHALL have parameter ALUOP_W, default 8, meaning ALU op-class field width.
REQ-003 SHALL have parameter ALUSEL_W, default 3, meaning ALU sub-select field width.
REQ-004 SHALL have parameter REGADDR_W, default 5, meaning destination register address width.
REQ-005 SHALL have parameter CNT_W, default 32, meaning stall counter width.
REQ-006 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port flush_i  in  1  synchronous pipeline flush.
REQ-009 SHALL have ports id_valid_i in 1 / id_ready_o out 1  decode-side handshake.
REQ-010 SHALL have ports aluop_i in ALUOP_W, alusel_i in ALUSEL_W, reg1_i in DATA_W, reg2_i in DATA_W, wd_i in REGADDR_W, wreg_i in 1  decode payload.
REQ-011 SHALL have ports ex_valid_o out 1 / ex_ready_i in 1  execute-side handshake.
REQ-012 SHALL have ports ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o  out  widths as inputs  execute payload.
REQ-013 SHALL have port stall_cnt_o  out  CNT_W  backpressure cycle count.

Function
REQ-014 SHALL hold two payload slots: MAIN (drives ex_* outputs) and SKID; all outputs registered, no combinational input-to-output path.
REQ-015 SHALL define push = id_valid_i & id_ready_o and pop = ex_valid_o & ex_ready_i.
REQ-016 SHALL implement states EMPTY (0 entries), ONE (MAIN valid), FULL (MAIN+SKID valid); id_ready_o = 1 in EMPTY/ONE, 0 in FULL; ex_valid_o = 1 in ONE/FULL.
REQ-017 SHALL transition EMPTY+push -> ONE, payload into MAIN; latency input-to-output exactly 1 cycle.
REQ-018 SHALL transition ONE+push+pop -> ONE, new payload into MAIN (full throughput, 1 per cycle).
REQ-019 SHALL transition ONE+push+!pop -> FULL, payload into SKID, MAIN unchanged.
REQ-020 SHALL transition ONE+!push+pop -> EMPTY; FULL+pop -> ONE with SKID moved into MAIN.
REQ-021 SHALL hold all state when neither push nor pop occurs; payload on ex_* stable while ex_valid_o=1 and ex_ready_i=0.
REQ-022 SHALL preserve issue order; no payload dropped or duplicated except by flush.
REQ-023 SHALL drive all ex_* payload outputs to zero in EMPTY (NOP bubble), so ex_wreg_o is never 1 while ex_valid_o=0.
REQ-024 SHALL, on flush_i=1, enter EMPTY next cycle, discard both slots and any same-cycle push; flush has priority over push and pop.
REQ-025 SHALL increment stall_cnt_o each cycle with ex_valid_o=1 and ex_ready_i=0, saturating at all-ones (no wrap); flush does not clear it.

Reset
REQ-026 SHALL on rst=1, immediately and independent of clk, enter EMPTY: ex_valid_o=0, id_ready_o=1, all ex_* payload 0, stall_cnt_o=0.
REQ-027 SHALL, if rst asserts mid-transfer, lose both slots; first push after rst deasserts is accepted normally.

Configuration
REQ-028 SHALL compile the stall counter only when macro ID_EX_STALL_CNT_EN is defined; otherwise stall_cnt_o is tied to constant 0, no counter flops exist, port list unchanged.

Verification
REQ-029 SHALL cover streaming: ex_ready_i=1, push reg1_i=0x11111111 then 0x22222222 on consecutive cycles -> ex_reg1_o shows them on cycles +1 and +2, ex_valid_o high both, id_ready_o stays 1.
REQ-030 SHALL cover backpressure: ex_ready_i=0, push A=0xA, B=0xB -> FULL, id_ready_o=0, ex_reg1_o=0xA held; raise ex_ready_i -> 0xA, then 0xB, then ex_valid_o=0.
REQ-031 SHALL cover flush in FULL with simultaneous push C -> next cycle ex_valid_o=0, all ex_* = 0, id_ready_o=1, C never appears.
REQ-032 SHALL cover async reset: assert rst between clock edges while FULL -> ex_valid_o=0 and payload 0 before next edge.
REQ-033 SHALL cover stall counter with ID_EX_STALL_CNT_EN and CNT_W=4: hold ex_valid_o=1, ex_ready_i=0 for 20 cycles -> stall_cnt_o=15; without macro -> stall_cnt_o=0 throughout.

Source files
------------

// File: rtl/id_ex_skid.sv
// Decode-to-execute pipeline register with a two-entry skid; optional stall counter under ID_EX_STALL_CNT_EN.
// Latency: 1 cycle input to output, 1 transfer/cycle; all outputs registered.
// Backpressure: id_ready_o drops only when both slots hold data; flush empties both slots next cycle.
module id_ex_skid #(
    parameter int DATA_W    = 32,
    parameter int ALUOP_W   = 8,
    parameter int ALUSEL_W  = 3,
    parameter int REGADDR_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    output logic                 id_ready_o,
    input  logic [ALUOP_W-1:0]   aluop_i,
    input  logic [ALUSEL_W-1:0]  alusel_i,
    input  logic [DATA_W-1:0]    reg1_i,
    input  logic [DATA_W-1:0]    reg2_i,
    input  logic [REGADDR_W-1:0] wd_i,
    input  logic                 wreg_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [ALUOP_W-1:0]   ex_aluop_o,
    output logic [ALUSEL_W-1:0]  ex_alusel_o,
    output logic [DATA_W-1:0]    ex_reg1_o,
    output logic [DATA_W-1:0]    ex_reg2_o,
    output logic [REGADDR_W-1:0] ex_wd_o,
    output logic                 ex_wreg_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    typedef struct packed {
        logic [ALUOP_W-1:0]   aluop;
        logic [ALUSEL_W-1:0]  alusel;
        logic [DATA_W-1:0]    reg1;
        logic [DATA_W-1:0]    reg2;
        logic [REGADDR_W-1:0] wd;
        logic                 wreg;
    } payload_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t   r_state;
    state_t   w_state_nxt;
    payload_t r_main;
    payload_t r_skid;
    payload_t w_main_nxt;
    payload_t w_skid_nxt;
    payload_t w_in;
    logic     r_ex_valid;
    logic     r_id_ready;
    logic     w_push;
    logic     w_pop;

    assign w_in   = '{aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i};
    assign w_push = id_valid_i & r_id_ready;
    assign w_pop  = r_ex_valid & ex_ready_i;

    // Handshake outputs are decoded from the next state so they leave flops directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_ex_valid <= 1'b0;
            r_id_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_ex_valid <= (w_state_nxt != S_EMPTY);
            r_id_ready <= (w_state_nxt != S_FULL);
        end
    end

    // MAIN is zeroed whenever the stage empties so ex_* presents a NOP bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = w_in;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_nxt = w_in;
                    end else if (w_push) begin
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = w_in;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = '0;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = '0;
                    w_skid_nxt  = '0;
                end
            endcase
        end
    end

    assign id_ready_o  = r_id_ready;
    assign ex_valid_o  = r_ex_valid;
    assign ex_aluop_o  = r_main.aluop;
    assign ex_alusel_o = r_main.alusel;
    assign ex_reg1_o   = r_main.reg1;
    assign ex_reg2_o   = r_main.reg2;
    assign ex_wd_o     = r_main.wd;
    assign ex_wreg_o   = r_main.wreg;

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturates rather than wraps; flush deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_ex_valid && !ex_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
